// File: rtl/clz_skip_divider_pkg.sv
// clz_skip_divider_pkg: shared width defaults and FSM state encoding for the divider
package clz_skip_divider_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
endpackage

// File: rtl/clz_skip_divider_if.sv
// clz_skip_divider_if: launch/result bundle between the EX stage and the divider
interface clz_skip_divider_if import clz_skip_divider_pkg::*; #(parameter int WIDTH = DEF_WIDTH) ();
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  modport master (output start, is_signed, dividend, divisor, input busy, done, div_by_zero, lo, hi);
  modport slave (input start, is_signed, dividend, divisor, output busy, done, div_by_zero, lo, hi);
endinterface

// File: rtl/div_abs_lzc.sv
// div_abs_lzc: operand magnitude and its leading-zero count (WIDTH when zero)
module div_abs_lzc import clz_skip_divider_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input  logic [WIDTH-1:0] i_op,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_mag,
  output logic [5:0]       o_lz
);
  assign o_mag = (i_signed && i_op[WIDTH-1]) ? -i_op : i_op;
  always_comb begin
    o_lz = 6'(WIDTH);
    for (int i = 0; i < WIDTH; i++) o_lz = o_mag[i] ? 6'(WIDTH - 1 - i) : o_lz;
  end
endmodule

// File: rtl/clz_skip_divider.sv
// clz_skip_divider: multi-cycle DIV/DIVU that skips the dividend's leading zeros
module clz_skip_divider import clz_skip_divider_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst,
  clz_skip_divider_if.slave bus
);
  state_t             r_state, w_next;
  logic [WIDTH-1:0]   w_ma, w_mb, r_q, r_r, r_mb, r_dvd, r_lo, r_hi, w_sh;
  logic [WIDTH:0]     w_t;
  logic [5:0]         w_lz_a, w_lz_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sq, r_sr, r_done, r_dbz, w_start;
  div_abs_lzc #(.WIDTH(WIDTH)) u_lzc_a (.i_op(bus.dividend), .i_signed(bus.is_signed), .o_mag(w_ma), .o_lz(w_lz_a));
  div_abs_lzc #(.WIDTH(WIDTH)) u_lzc_b (.i_op(bus.divisor), .i_signed(bus.is_signed), .o_mag(w_mb), .o_lz(w_lz_b));
  assign w_start = bus.start && r_state == S_IDLE;
  assign w_sh    = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_t     = {1'b0, w_sh} - {1'b0, r_mb};
  always_comb begin
    w_next = S_IDLE;
    w_next = r_state == S_IDLE ? (bus.start ? ((w_lz_a == 6'(WIDTH) || w_lz_b == 6'(WIDTH)) ? S_FIX : S_RUN) : S_IDLE)
           : r_state == S_RUN  ? (r_cnt == CNT_W'(1) ? S_FIX : S_RUN)
           : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_q, r_r, r_mb, r_dvd, r_lo, r_hi} <= '0;
      {r_cnt, r_sq, r_sr, r_done, r_dbz} <= '0;
    end else begin
      r_done <= r_state == S_FIX;
      if (w_start) begin
        r_sq  <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
        r_sr  <= bus.is_signed & bus.dividend[WIDTH-1];
        r_mb  <= w_mb;
        r_dvd <= bus.dividend;
        r_q   <= w_ma << w_lz_a;
        r_r   <= '0;
        r_cnt <= CNT_W'(WIDTH) - CNT_W'(w_lz_a);
        r_dbz <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_q   <= {r_q[WIDTH-2:0], ~w_t[WIDTH]};
        r_r   <= w_t[WIDTH] ? w_sh : w_t[WIDTH-1:0];
        r_cnt <= r_cnt - CNT_W'(1);
      end else if (r_state == S_FIX) begin
        r_lo  <= r_mb == '0 ? '1 : (r_sq ? -r_q : r_q);
        r_hi  <= r_mb == '0 ? r_dvd : (r_sr ? -r_r : r_r);
        r_dbz <= r_mb == '0;
      end
    end
  end
  assign bus.busy        = r_state != S_IDLE;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.lo          = r_lo;
  assign bus.hi          = r_hi;
endmodule

// File: tb/tb_clz_skip_divider.sv
// tb_clz_skip_divider: directed and random checks of quotient, remainder, latency and control
module tb_clz_skip_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  clz_skip_divider_if bus ();
  clz_skip_divider dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.is_signed = s; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.is_signed = ~s; bus.dividend = ~a; bus.divisor = ~b;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) n++;
    end
  endtask

  task automatic op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] e_lo, input logic [31:0] e_hi, input logic e_dbz, input int e_lat);
    int lat;
    launch(s, a, b);
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    check({tag, ".dbz_clr"}, 32'(bus.div_by_zero), 32'd0);
    wait_done(lat);
    check({tag, ".lat"}, 32'(lat), 32'(e_lat));
    check({tag, ".lo"}, bus.lo, e_lo);
    check({tag, ".hi"}, bus.hi, e_hi);
    check({tag, ".dbz"}, 32'(bus.div_by_zero), 32'(e_dbz));
    check({tag, ".idle"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".width"}, 32'(bus.done), 32'd0);
  endtask

  function automatic int sig_bits(input logic [31:0] x);
    int n = 0;
    while (x != 0) begin
      x = x >> 1;
      n++;
    end
    return n;
  endfunction

  initial begin
    int lat, n;
    logic [31:0] a, b, m, e_lo, e_hi;
    logic s;
    longint la, lb, lq, lr;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #12;
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.dbz", 32'(bus.div_by_zero), 32'd0);
    check("rst.lo", bus.lo, 32'd0);
    check("rst.hi", bus.hi, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 8);
    op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 4);
    op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 4);
    op("divu_0_5", 1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1);
    op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    op("divu_9_0", 1'b0, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b1, 1);
    op("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1, 1);
    op("divu_after_dbz", 1'b0, 32'd50, 32'd3, 32'd16, 32'd2, 1'b0, 7);
    // a start pulse mid-flight must leave the running op untouched
    launch(1'b0, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat);
    check("busy_start.lat", 32'(lat), 32'd5);
    check("busy_start.lo", bus.lo, 32'd14);
    check("busy_start.hi", bus.hi, 32'd2);
    count_done(40, n);
    check("busy_start.extra_done", 32'(n), 32'd0);
    // back-to-back: second launch sits in the done cycle of the first
    launch(1'b0, 32'd100, 32'd7);
    wait_done(lat);
    check("b2b.first_lat", 32'(lat), 32'd8);
    check("b2b.first_lo", bus.lo, 32'd14);
    launch(1'b0, 32'd1000, 32'd10);
    wait_done(lat);
    check("b2b.second_lat", 32'(lat), 32'd11);
    check("b2b.second_lo", bus.lo, 32'd100);
    check("b2b.second_hi", bus.hi, 32'd0);
    @(negedge clk);
    launch(1'b0, 32'hFFFF_FFFF, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst.busy", 32'(bus.busy), 32'd0);
    check("arst.done", 32'(bus.done), 32'd0);
    check("arst.lo", bus.lo, 32'd0);
    check("arst.hi", bus.hi, 32'd0);
    @(negedge clk) rst = 1'b0;
    count_done(40, n);
    check("arst.no_done", 32'(n), 32'd0);
    @(negedge clk);
    op("post_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 8);
    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) a = ~a;
      if ($urandom_range(0, 3) == 0) b = ~b;
      if (b == 0) b = 32'd1;
      if (s) begin
        la = longint'($signed(a)); lb = longint'($signed(b));
        lq = la / lb; lr = la % lb;
        e_lo = lq[31:0]; e_hi = lr[31:0];
      end else begin
        e_lo = a / b; e_hi = a % b;
      end
      m = (s && a[31]) ? -a : a;
      op("rnd", s, a, b, e_lo, e_hi, 1'b0, sig_bits(m) + 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
